// File: rtl/sync_payload_pkg.sv
// sync_payload_pkg
//   Shared definitions for the sync-pattern payload deserializer and the
//   "110011" detector that feeds it.
//   - sync_payload_state_t : deserializer FSM states
//   - SYNC_PATTERN_W       : length of the sync pattern in bits
//   - SYNC_PATTERN         : the sync pattern, first received bit in the MSB
package sync_payload_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CAPTURE = 2'd1,
        PARITY  = 2'd2,
        HOLD    = 2'd3
    } sync_payload_state_t;

    localparam int SYNC_PATTERN_W = 6;
    localparam logic [SYNC_PATTERN_W-1:0] SYNC_PATTERN = 6'b110011;

endpackage

// File: rtl/sync_payload_deserializer_shift_reg.sv
// payload_shift_reg
//   Serial-in / parallel-out shift register plus the payload bit counter.
//   New bits enter on the LSB side, so the first bit received ends up in the
//   MSB once PAYLOAD_W bits have been shifted in.
//   Ports:
//     clk      in   clock
//     rst      in   synchronous active-high reset (bit counter only)
//     load     in   shift din in and advance the bit counter
//     din      in   serial data
//     clear    in   zero the bit counter (wins over load for the counter)
//     data     out  PAYLOAD_W-bit parallel contents
//     bit_cnt  out  number of bits shifted in since the last clear
module payload_shift_reg
    import sync_payload_pkg::*;
#(
    parameter int PAYLOAD_W = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load,
    input  logic                             din,
    input  logic                             clear,
    output logic [PAYLOAD_W-1:0]             data,
    output logic [$clog2(PAYLOAD_W+1)-1:0]   bit_cnt
);

    localparam int CNT_W = $clog2(PAYLOAD_W + 1);

    // Data path carries no reset: its contents are only consumed after a
    // full frame has been shifted in.
    always_ff @(posedge clk) begin
        if (load) begin
            data <= {data[PAYLOAD_W-2:0], din};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (clear) begin
            bit_cnt <= '0;
        end else if (load) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sync_payload_deserializer.sv
// sync_payload_deserializer
//   Downstream stage of the "110011" serial sync detector. After each
//   sync_detected pulse, the next PAYLOAD_W bits of the serial stream are
//   collected into a word (first bit = MSB) and presented on a valid/ready
//   handshake. A frame still held when the next sync arrives is discarded
//   and reported with a one-cycle overrun pulse.
//
//   Build option: define SYNC_PAYLOAD_PARITY_EN to expect one trailing
//   even-parity bit per frame; parity_err then reports the check result for
//   the held frame and latency grows by one cycle. Undefined, parity_err is 0.
//
//   Ports:
//     clk            in   clock, posedge
//     rst            in   synchronous active-high reset
//     a              in   serial bit stream (same signal the detector sees)
//     sync_detected  in   detector pulse, high in the cycle of payload bit 0
//     payload_data   out  captured word, valid while payload_valid is high
//     payload_valid  out  payload_data holds an unaccepted frame
//     payload_ready  in   consumer accepts the frame
//     overrun        out  one-cycle pulse per discarded frame
//     parity_err     out  parity result of the held frame
module sync_payload_deserializer
    import sync_payload_pkg::*;
#(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a,
    input  logic                 sync_detected,
    output logic [PAYLOAD_W-1:0] payload_data,
    output logic                 payload_valid,
    input  logic                 payload_ready,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int CNT_W = $clog2(PAYLOAD_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PAYLOAD_W - 1);

    sync_payload_state_t    state;
    logic [PAYLOAD_W-1:0]   sr_data;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   sr_load;
    logic                   sr_clear;
    logic                   capture_last;
    logic                   hold_entry;

    payload_shift_reg #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .load    (sr_load),
        .din     (a),
        .clear   (sr_clear),
        .data    (sr_data),
        .bit_cnt (bit_cnt)
    );

    always_comb begin
        capture_last = (state == CAPTURE) && (bit_cnt == LAST_BIT);
`ifdef SYNC_PAYLOAD_PARITY_EN
        hold_entry   = (state == PARITY);
`else
        hold_entry   = capture_last;
`endif
        // A sync seen in HUNT or HOLD makes the current bit payload bit 0,
        // so it is shifted in on the same edge; nothing is lost between
        // back-to-back frames.
        sr_load  = (state == CAPTURE) ||
                   (sync_detected && ((state == HUNT) || (state == HOLD)));
        sr_clear = hold_entry ||
                   ((state == HOLD) && payload_ready && !sync_detected);
    end

`ifdef SYNC_PAYLOAD_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= HUNT;
            payload_data  <= '0;
            payload_valid <= 1'b0;
            overrun       <= 1'b0;
            parity_err    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            case (state)
                HUNT: begin
                    if (sync_detected) state <= CAPTURE;
                end
                CAPTURE: begin
                    if (capture_last) state <= PARITY;
                end
                PARITY: begin
                    // Even parity over payload plus parity bit: 0 means good.
                    state         <= HOLD;
                    payload_data  <= sr_data;
                    parity_err    <= (^sr_data) ^ a;
                    payload_valid <= 1'b1;
                end
                HOLD: begin
                    if (sync_detected) begin
                        state         <= CAPTURE;
                        payload_valid <= 1'b0;
                        overrun       <= !payload_ready;
                    end else if (payload_ready) begin
                        state         <= HUNT;
                        payload_valid <= 1'b0;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end
`else
    // The word is complete on the edge that samples the last bit, so the
    // output register takes the shift register's next value directly and the
    // current MSB (about to be shifted out) is never needed.
    logic sr_msb_unused;
    assign sr_msb_unused = sr_data[PAYLOAD_W-1];
    assign parity_err    = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= HUNT;
            payload_data  <= '0;
            payload_valid <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            overrun <= 1'b0;
            case (state)
                HUNT: begin
                    if (sync_detected) state <= CAPTURE;
                end
                CAPTURE: begin
                    if (capture_last) begin
                        state         <= HOLD;
                        payload_data  <= {sr_data[PAYLOAD_W-2:0], a};
                        payload_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (sync_detected) begin
                        state         <= CAPTURE;
                        payload_valid <= 1'b0;
                        overrun       <= !payload_ready;
                    end else if (payload_ready) begin
                        state         <= HUNT;
                        payload_valid <= 1'b0;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_sync_payload_deserializer.sv
// tb_sync_payload_deserializer
//   Self-checking bench for sync_payload_deserializer (PAYLOAD_W = 8).
//   The detector is scripted: the bench raises sync_detected exactly in the
//   cycle of payload bit 0 (and at chosen points inside a payload), so frame
//   boundaries are fully under bench control. Expected words are queued when
//   a frame is sent and compared at every accepted handshake.
module tb_sync_payload_deserializer;
    import sync_payload_pkg::*;

    localparam int W = 8;
`ifdef SYNC_PAYLOAD_PARITY_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         a = 1'b0;
    logic         sync_detected = 1'b0;
    logic         payload_ready = 1'b0;
    logic [W-1:0] payload_data;
    logic         payload_valid;
    logic         overrun;
    logic         parity_err;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int hs_cnt = 0;
    int ovr_cnt = 0;
    int ovr_cyc = -1;
    int valid_cnt = 0;
    int rise_cyc = -1;
    int last_t0 = 0;
    logic prev_valid = 1'b0;
    logic [W:0] exp_q[$];

    sync_payload_deserializer #(
        .PAYLOAD_W (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .a             (a),
        .sync_detected (sync_detected),
        .payload_data  (payload_data),
        .payload_valid (payload_valid),
        .payload_ready (payload_ready),
        .overrun       (overrun),
        .parity_err    (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        logic [W:0] e;
        if (payload_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = payload_valid;
        if (payload_valid) valid_cnt++;
        if (overrun) begin
            ovr_cnt++;
            ovr_cyc = cyc;
        end
        if (payload_valid && payload_ready) begin
            hs_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_unexpected: got data=%h perr=%b, expected no frame", payload_data, parity_err);
            end else begin
                e = exp_q.pop_front();
                if ({parity_err, payload_data} !== e)
                    $display("FAIL scoreboard_frame: got perr=%b data=%h, expected perr=%b data=%h", parity_err, payload_data, e[W], e[W-1:0]);
                else
                    passed++;
            end
        end
    end

    task automatic drive(input logic b, input logic det);
        a = b;
        sync_detected = det;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
    endtask

    task automatic send_sync();
        logic [SYNC_PATTERN_W-1:0] pat;
        pat = SYNC_PATTERN;
        for (int i = SYNC_PATTERN_W - 1; i >= 0; i--) drive(pat[i], 1'b0);
    endtask

    // Payload MSB first; detector pulse on bit 0 plus any bits in extra_det.
    task automatic send_payload(input logic [W-1:0] word, input logic pbit, input logic [W-1:0] extra_det);
        last_t0 = cyc;
        for (int i = W - 1; i >= 0; i--) drive(word[i], (i == W - 1) || extra_det[i]);
`ifdef SYNC_PAYLOAD_PARITY_EN
        drive(pbit, 1'b0);
`else
        if (pbit !== 1'b0) $display("note: parity bit ignored in this build");
`endif
    endtask

    task automatic expect_frame(input logic [W-1:0] word, input logic pbit);
`ifdef SYNC_PAYLOAD_PARITY_EN
        exp_q.push_back({(^word) ^ pbit, word});
`else
        exp_q.push_back({1'b0, word});
        if (pbit !== 1'b0) $display("note: parity expectation ignored in this build");
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        payload_ready = 1'b0;
        idle(3);
        total++; if (payload_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", payload_valid); else passed++;
        total++; if (payload_data !== '0) $display("FAIL reset_data: got %h, expected 00", payload_data); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b, expected 0", overrun); else passed++;
        total++; if (parity_err !== 1'b0) $display("FAIL reset_parity: got %b, expected 0", parity_err); else passed++;
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_basic();
        int h0, v0;
        payload_ready = 1'b1;
        h0 = hs_cnt; v0 = valid_cnt; rise_cyc = -1;
        expect_frame(8'hA5, 1'b0);
        send_sync();
        send_payload(8'hA5, 1'b0, '0);
        idle(4);
        total++; if (rise_cyc - last_t0 !== LAT) $display("FAIL basic_latency: got %0d cycles, expected %0d", rise_cyc - last_t0, LAT); else passed++;
        total++; if (hs_cnt - h0 !== 1) $display("FAIL basic_frames: got %0d, expected 1", hs_cnt - h0); else passed++;
        total++; if (valid_cnt - v0 !== 1) $display("FAIL basic_valid_width: got %0d cycles, expected 1", valid_cnt - v0); else passed++;
        total++; if (exp_q.size() !== 0) $display("FAIL basic_queue: got %0d pending, expected 0", exp_q.size()); else passed++;
    endtask

    task automatic test_back_to_back();
        int h0, v0, o0;
        payload_ready = 1'b1;
        h0 = hs_cnt; v0 = valid_cnt; o0 = ovr_cnt;
        expect_frame(8'h3C, 1'b0);
        expect_frame(8'hC3, 1'b0);
        send_sync();
        send_payload(8'h3C, 1'b0, '0);
        send_sync();
        send_payload(8'hC3, 1'b0, '0);
        idle(4);
        total++; if (hs_cnt - h0 !== 2) $display("FAIL b2b_frames: got %0d, expected 2", hs_cnt - h0); else passed++;
        total++; if (valid_cnt - v0 !== 2) $display("FAIL b2b_valid_width: got %0d cycles, expected 2", valid_cnt - v0); else passed++;
        total++; if (ovr_cnt - o0 !== 0) $display("FAIL b2b_overrun: got %0d pulses, expected 0", ovr_cnt - o0); else passed++;
    endtask

    task automatic test_zero_gap();
        int h0, o0;
        payload_ready = 1'b1;
        h0 = hs_cnt; o0 = ovr_cnt;
        expect_frame(8'h96, 1'b0);
        expect_frame(8'h69, 1'b0);
        send_sync();
        send_payload(8'h96, 1'b0, '0);
        // Next sync lands in the HOLD cycle of the first frame.
        send_payload(8'h69, 1'b0, '0);
        idle(4);
        total++; if (rise_cyc - last_t0 !== LAT) $display("FAIL zerogap_latency: got %0d cycles, expected %0d", rise_cyc - last_t0, LAT); else passed++;
        total++; if (hs_cnt - h0 !== 2) $display("FAIL zerogap_frames: got %0d, expected 2", hs_cnt - h0); else passed++;
        total++; if (ovr_cnt - o0 !== 0) $display("FAIL zerogap_overrun: got %0d pulses, expected 0", ovr_cnt - o0); else passed++;
    endtask

    task automatic test_stall_overrun();
        int h0, o0;
        payload_ready = 1'b0;
        h0 = hs_cnt; o0 = ovr_cnt;
        send_sync();
        send_payload(8'h5A, 1'b0, '0);
        idle(3);
        total++; if (payload_valid !== 1'b1) $display("FAIL stall_valid_held: got %b, expected 1", payload_valid); else passed++;
        total++; if (payload_data !== 8'h5A) $display("FAIL stall_data_held: got %h, expected 5a", payload_data); else passed++;
        expect_frame(8'h0F, 1'b0);
        send_sync();
        send_payload(8'h0F, 1'b0, '0);
        idle(3);
        total++; if (ovr_cnt - o0 !== 1) $display("FAIL stall_overrun_count: got %0d, expected 1", ovr_cnt - o0); else passed++;
        total++; if (ovr_cyc !== last_t0 + 1) $display("FAIL stall_overrun_time: got cycle %0d, expected %0d", ovr_cyc, last_t0 + 1); else passed++;
        total++; if (payload_valid !== 1'b1) $display("FAIL stall_valid_new: got %b, expected 1", payload_valid); else passed++;
        total++; if (payload_data !== 8'h0F) $display("FAIL stall_data_new: got %h, expected 0f", payload_data); else passed++;
        payload_ready = 1'b1;
        idle(3);
        total++; if (hs_cnt - h0 !== 1) $display("FAIL stall_frames: got %0d, expected 1", hs_cnt - h0); else passed++;
        total++; if (payload_valid !== 1'b0) $display("FAIL stall_valid_drop: got %b, expected 0", payload_valid); else passed++;
    endtask

    task automatic test_sync_in_payload();
        int h0;
        payload_ready = 1'b1;
        h0 = hs_cnt;
        expect_frame(8'h33, 1'b0);
        send_sync();
        // "110011" completes at payload bit 3, so a detector would fire on bit 4.
        send_payload(8'h33, 1'b0, 8'b0000_1000);
        idle(4);
        total++; if (hs_cnt - h0 !== 1) $display("FAIL syncin_frames: got %0d, expected 1", hs_cnt - h0); else passed++;
        total++; if (rise_cyc - last_t0 !== LAT) $display("FAIL syncin_latency: got %0d cycles, expected %0d", rise_cyc - last_t0, LAT); else passed++;
    endtask

    task automatic test_reset_mid();
        int h0, v0, o0;
        payload_ready = 1'b1;
        send_sync();
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        h0 = hs_cnt; v0 = valid_cnt; o0 = ovr_cnt;
        rst = 1'b1;
        drive(1'b1, 1'b0);
        total++; if ({payload_valid, overrun, parity_err} !== 3'b000) $display("FAIL rstmid_ctrl: got valid/ovr/perr=%b, expected 000", {payload_valid, overrun, parity_err}); else passed++;
        total++; if (payload_data !== '0) $display("FAIL rstmid_data: got %h, expected 00", payload_data); else passed++;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) drive(i[0], 1'b0);
        total++; if (valid_cnt - v0 !== 0) $display("FAIL rstmid_valid: got %0d valid cycles, expected 0", valid_cnt - v0); else passed++;
        total++; if (ovr_cnt - o0 !== 0) $display("FAIL rstmid_overrun: got %0d pulses, expected 0", ovr_cnt - o0); else passed++;
        idle(2);
        expect_frame(8'h81, 1'b0);
        send_sync();
        send_payload(8'h81, 1'b0, '0);
        idle(3);
        total++; if (hs_cnt - h0 !== 1) $display("FAIL rstmid_recover: got %0d frames, expected 1", hs_cnt - h0); else passed++;
    endtask

    task automatic test_parity();
`ifdef SYNC_PAYLOAD_PARITY_EN
        int h0;
        payload_ready = 1'b1;
        h0 = hs_cnt;
        expect_frame(8'hA5, 1'b0);
        expect_frame(8'hA5, 1'b1);
        send_sync();
        send_payload(8'hA5, 1'b0, '0);
        send_sync();
        send_payload(8'hA5, 1'b1, '0);
        idle(4);
        total++; if (hs_cnt - h0 !== 2) $display("FAIL parity_frames: got %0d, expected 2", hs_cnt - h0); else passed++;
        total++; if (rise_cyc - last_t0 !== W + 1) $display("FAIL parity_latency: got %0d cycles, expected %0d", rise_cyc - last_t0, W + 1); else passed++;
`else
        payload_ready = 1'b1;
        idle(1);
        total++; if (parity_err !== 1'b0) $display("FAIL parity_tied: got %b, expected 0", parity_err); else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_zero_gap();
        test_stall_overrun();
        test_sync_in_payload();
        test_reset_mid();
        test_parity();
        idle(2);
        total++; if (exp_q.size() !== 0) $display("FAIL final_queue: got %0d pending frames, expected 0", exp_q.size()); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, got no finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/sync_payload_deserializer.md
# sync_payload_deserializer

Downstream stage of the "110011" serial sync-pattern detector. Consumes the detector's single-cycle `detected` pulse and the same serial bit stream. Deserialises the `PAYLOAD_W` bits that immediately follow each sync pattern into a parallel word and hands that word on over a valid/ready handshake. Reports frames lost because the consumer stalled.

## Interface

- `PAYLOAD_W`, default 8: payload bits per frame; legal range 2..32.
- `clk`  input  1: clock; all logic on posedge.
- `rst`  input  1: reset, synchronous, active-high.
- `a`  input  1: serial bit stream, the same signal that feeds the detector.
- `sync_detected`  input  1: detector output (Moore). High in the cycle right after the last sync bit was sampled.
- `payload_data`  output  `PAYLOAD_W`: captured word. The first received bit is the MSB.
- `payload_valid`  output  1: `payload_data` holds an unaccepted frame.
- `payload_ready`  input  1: consumer accepts the frame when high together with `payload_valid`.
- `overrun`  output  1: one-cycle pulse when a captured frame is discarded.
- `parity_err`  output  1: parity result for the held frame. Constant 0 when the parity feature is compiled out.

## Operation

- States: HUNT, CAPTURE, PARITY (only present with the macro), HOLD.
- HUNT
  - `sync_detected`=1: the `a` sampled at this edge is payload bit 0. It is shifted in, bit_cnt becomes 1, and the state goes to CAPTURE.
- CAPTURE
  - Each edge shifts `a` in LSB-side (`{data[W-2:0], a}`) and increments bit_cnt.
  - `sync_detected` is ignored.
  - At the edge that samples bit `PAYLOAD_W-1`, go to HOLD, or to PARITY with the macro.
- PARITY
  - Sample one bit.
  - Register `parity_err` = XOR of payload bits and the parity bit (even parity, so a correct frame gives 0).
  - Go to HOLD.
- HOLD
  - `payload_valid`=1. `payload_data` and `parity_err` are stable.
  - `payload_ready`=1 and `sync_detected`=0: go to HUNT.
  - `payload_ready`=1 and `sync_detected`=1 in the same cycle: the handshake completes and a new capture starts from the current `a`, going straight to CAPTURE with no lost bit.
  - `payload_ready`=0 and `sync_detected`=1: discard the held frame, pulse `overrun` next cycle, and start a new capture (CAPTURE) from the current `a`.
  - `payload_ready`=0 and `sync_detected`=0: stay in HOLD.
- bit_cnt width: `$clog2(PAYLOAD_W+1)`. It is cleared on entry to HUNT and HOLD.
- `payload_data` holds its last value outside HOLD. It is meaningful only while `payload_valid`=1.

## Timing

- Reset values: state HUNT, `payload_data`=0, `payload_valid`=0, `overrun`=0, `parity_err`=0, bit_cnt=0.
- Reset asserted mid-capture or in HOLD: the partial or held frame is dropped silently, with no `overrun`.
- Latency:
  - `sync_detected` cycle = bit 0.
  - `payload_valid` rises on the edge that samples bit `PAYLOAD_W-1`. It is visible `PAYLOAD_W` cycles after the `sync_detected` cycle.
  - Add 1 cycle with the parity feature.
- `payload_valid` falls on the edge after the handshake cycle.
- Throughput: back-to-back frames with zero gap are sustained when `payload_ready` is held at 1.
- `overrun` is registered and high for exactly one cycle per discarded frame.

## Configuration

- `SYNC_PAYLOAD_PARITY_EN` defined:
  - Each frame carries one trailing even-parity bit after the payload.
  - The PARITY state exists and `parity_err` is driven.
  - Latency is `PAYLOAD_W`+1.
- Not defined:
  - No parity bit is expected and the PARITY state is absent.
  - `parity_err` is tied to 0 and latency is `PAYLOAD_W`.

## Structure

- Package `sync_payload_pkg`:
  - state enum `sync_payload_state_t` (HUNT, CAPTURE, PARITY, HOLD).
  - constant `SYNC_PATTERN` = 6'b110011.
  - constant `SYNC_PATTERN_W` = 6, shared with the detector bench.
- Sub-module `payload_shift_reg` (`PAYLOAD_W`):
  - ports: load-enable, serial in, clear, and parallel out.
  - contains the shift register and bit counter.
  - the FSM stays in the top module.

## Test plan

- **Basic frame:** `PAYLOAD_W`=8, `payload_ready`=1. Drive 110011 then 10100101. Expect `payload_data`=8'hA5 and `payload_valid` high for 1 cycle, 8 cycles after `sync_detected`.
- **Back-to-back:** 110011, 8'h3C, 110011, 8'hC3 with no gaps. Expect two valid frames 3C then C3, each with a 1-cycle valid, and `overrun` never asserted.
- **Stall then overrun:** hold `payload_ready`=0 after frame 8'h5A, then send sync and 8'h0F. Expect `overrun` pulsed once 1 cycle after the second `sync_detected`, then `payload_data`=8'h0F with `payload_valid` held until ready.
- **Sync inside payload:** payload 8'h33 followed by more bits forms "110011" across the boundary. Expect `sync_detected` during CAPTURE to be ignored and exactly 8'h33 delivered.
- **Reset mid-capture:** assert `rst` after 4 payload bits. Expect all outputs 0 and state HUNT next cycle, and no `payload_valid`/`overrun` until a new sync.
- **Parity (macro defined):** payload 8'hA5 with parity bit 0, then 8'hA5 with parity bit 1. Expect `parity_err`=0 then 1, each with `payload_valid` 9 cycles after `sync_detected`.
